dmem_mmio_responder: RTL

// - Responder side of the pipeline's MEM-stage data port: takes byte address, write data and MemWrite/MemRead from the CPU.
// - Returns read data combinationally within the same cycle; the CPU has no memory stall.
// - Decodes the port into a word RAM plus a small MMIO page: LED register, free-running cycle counter, byte TX FIFO.
// - The TX FIFO drains through a valid/ready stream to an external consumer such as a UART TX.

---
 rtl/dmem_mmio_responder_pkg.sv | 41 ++++
 rtl/dmem_mmio_responder_if.sv | 24 ++
 rtl/dmem_mmio_responder_sync_fifo.sv | 58 +++++
 rtl/dmem_mmio_responder.sv | 120 ++++++++++++
 4 files changed

// File: rtl/dmem_mmio_responder_pkg.sv
// Shared definitions for the MEM-stage data port responder.
// Holds the MMIO page-select bit, the MMIO register offsets, the STATUS bit
// layout and small saturating-arithmetic helpers used by the top level.
package dmem_mmio_responder_pkg;

    // addr[PAGE_BIT] = 1 selects the MMIO page, 0 selects the word RAM.
    localparam int PAGE_BIT = 8;

    // MMIO register offsets (word index addr[4:2] within the page).
    typedef enum logic [2:0] {
        OFS_LED    = 3'd0,
        OFS_CYCLE  = 3'd1,
        OFS_TXDATA = 3'd2,
        OFS_STATUS = 3'd3,
        OFS_DROP   = 3'd4
    } mmio_ofs_e;

    // STATUS register bit positions.
    localparam int ST_FULL_BIT  = 0;
    localparam int ST_EMPTY_BIT = 1;
    localparam int ST_COUNT_LSB = 4;

    // Occupancy shown in STATUS is a 4-bit field that pins at 15.
    function automatic logic [3:0] sat_count4(input logic [31:0] n);
        if (n > 32'd15) begin
            return 4'hF;
        end else begin
            return n[3:0];
        end
    endfunction

    // 8-bit increment that sticks at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return 8'hFF;
        end else begin
            return v + 8'd1;
        end
    endfunction

endpackage

// File: rtl/dmem_mmio_responder_if.sv
// Bus bundle between the CPU MEM stage / TX consumer and the responder.
// CPU side : addr, wdata, mem_we, mem_re (to responder), rdata (from responder).
// TX stream: tx_valid, tx_data (from responder), tx_ready (to responder).
// slave modport is the responder's view, master is the environment's view.
interface dmem_mmio_responder_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] rdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    modport slave (
        input  addr, wdata, mem_we, mem_re, tx_ready,
        output rdata, tx_valid, tx_data
    );

    modport master (
        output addr, wdata, mem_we, mem_re, tx_ready,
        input  rdata, tx_valid, tx_data
    );
endinterface

// File: rtl/dmem_mmio_responder_sync_fifo.sv
// Synchronous FIFO with async active-high reset.
// Ports: clk, reset, push/wdata (enqueue), pop (dequeue head), rdata (head,
// zero when empty), full, empty, count (occupancy).
// A push while full is accepted only when a pop happens in the same cycle.
module dmem_mmio_responder_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             pop_ok_s;
    logic             push_ok_s;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign count     = wr_ptr_r - rd_ptr_r;
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);
    assign rdata     = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

    // Pointer registers; reset discards all queued entries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage; when full with a concurrent pop, the tail slot is the head
    // being vacated, so overwriting it at the same edge is safe.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end
endmodule

// File: rtl/dmem_mmio_responder.sv
// MEM-stage data port responder: word RAM plus a small MMIO page.
// Ports: clk, reset (async, active-high), bus (slave modport: CPU address,
// store data, MemWrite/MemRead, combinational rdata, TX valid/ready stream),
// led_out (LED register).
// MMIO page: LED (RW), CYCLE (free-running counter), TXDATA (FIFO push),
// STATUS (full/empty/occupancy), DROP (rejected-push counter).
module dmem_mmio_responder
    import dmem_mmio_responder_pkg::*;
#(
    parameter int RAM_AW     = 6,
    parameter int FIFO_DEPTH = 8,
    parameter int LED_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_mmio_responder_if.slave bus,
    output logic [LED_W-1:0]     led_out
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       ram_r [2**RAM_AW];
    logic [LED_W-1:0]  led_r;
    logic [31:0]       cycle_r;
    logic [7:0]        drop_r;

    logic              is_mmio_s;
    mmio_ofs_e         ofs_s;
    logic [RAM_AW-1:0] ram_idx_s;
    logic              mmio_we_s;
    logic              push_s;
    logic              pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CW-1:0]     fifo_count_s;
    logic [7:0]        fifo_head_s;
    logic [31:0]       rdata_s;
    logic              unused_s;

    assign is_mmio_s = bus.addr[PAGE_BIT];
    assign ofs_s     = mmio_ofs_e'(bus.addr[4:2]);
    assign ram_idx_s = bus.addr[RAM_AW+1:2];
    assign mmio_we_s = bus.mem_we && is_mmio_s;
    assign push_s    = mmio_we_s && (ofs_s == OFS_TXDATA);
    assign pop_s     = !fifo_empty_s && bus.tx_ready;

    // mem_re is informational only: reads carry no side effects.
    assign unused_s  = ^{bus.mem_re, bus.addr[31:PAGE_BIT+1], bus.addr[1:0], bus.wdata};

    dmem_mmio_responder_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .wdata (bus.wdata[7:0]),
        .pop   (pop_s),
        .rdata (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign bus.tx_valid = !fifo_empty_s;
    assign bus.tx_data  = fifo_head_s;
    assign led_out      = led_r;

    // Word RAM; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (bus.mem_we && !is_mmio_s) begin
            ram_r[ram_idx_s] <= bus.wdata;
        end
    end

    // LED, CYCLE and DROP registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_r   <= {LED_W{1'b0}};
            cycle_r <= 32'd0;
            drop_r  <= 8'd0;
        end else begin
            if (mmio_we_s && (ofs_s == OFS_LED)) begin
                led_r <= bus.wdata[LED_W-1:0];
            end
            if (mmio_we_s && (ofs_s == OFS_CYCLE)) begin
                cycle_r <= 32'd0;
            end else begin
                cycle_r <= cycle_r + 32'd1;
            end
            // A push is lost only when full and nothing drains this cycle.
            if (mmio_we_s && (ofs_s == OFS_DROP)) begin
                drop_r <= 8'd0;
            end else if (push_s && fifo_full_s && !pop_s) begin
                drop_r <= sat_inc8(drop_r);
            end
        end
    end

    // Combinational read mux; unmapped and write-only offsets read zero.
    always_comb begin
        rdata_s = 32'd0;
        if (is_mmio_s) begin
            case (ofs_s)
                OFS_LED:    rdata_s[LED_W-1:0] = led_r;
                OFS_CYCLE:  rdata_s = cycle_r;
                OFS_STATUS: begin
                    rdata_s[ST_FULL_BIT]          = fifo_full_s;
                    rdata_s[ST_EMPTY_BIT]         = fifo_empty_s;
                    rdata_s[ST_COUNT_LSB +: 4]    = sat_count4(32'(fifo_count_s));
                end
                OFS_DROP:   rdata_s[7:0] = drop_r;
                default:    rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = ram_r[ram_idx_s];
        end
    end

    assign bus.rdata = rdata_s;
endmodule
